// File: rtl/store_pkg.sv
// Shared types and size encodings for the store pack buffer.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Upper bound on the byte-address width an entry can carry.
  localparam int MAX_ADDR_W = 32;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] waddr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } store_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational narrowing of 32-bit store data into byte lanes with strobes.
// STORE_MISALIGN_TRAP_EN: flag misaligned stores instead of force-aligning them.
module store_lane_pack
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic [1:0]        i_size,
  output store_entry_t      o_entry,
  output logic              o_misaligned
);

  logic [1:0] w_lane;
  logic [1:0] w_size;

  assign w_lane = i_addr[1:0];

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_size       = i_size;
  assign o_misaligned = ((i_size == SZ_HALF) && w_lane[0]) ||
                        ((i_size == SZ_WORD) && (w_lane != 2'b00)) ||
                        (i_size == SZ_RSVD);
`else
  // Reserved size degrades to a word store; misalignment is absorbed below.
  assign w_size       = (i_size == SZ_RSVD) ? SZ_WORD : i_size;
  assign o_misaligned = 1'b0;
`endif

  always_comb begin
    o_entry       = '0;
    o_entry.waddr = MAX_ADDR_W'({i_addr[ADDR_W-1:2], 2'b00});
    case (w_size)
      SZ_BYTE: begin
        o_entry.wdata = {4{i_data[7:0]}};
        o_entry.wstrb = 4'b0001 << w_lane;
      end
      SZ_HALF: begin
        // Using only lane[1] naturally aligns an odd halfword address.
        o_entry.wdata = {2{i_data[15:0]}};
        o_entry.wstrb = w_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_entry.wdata = i_data;
        o_entry.wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/store_pack_buffer.sv
// Store lane packer plus a small write FIFO between the MEM stage and data memory.
// STORE_MISALIGN_TRAP_EN: drop misaligned stores and pulse misalign.
module store_pack_buffer
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              misalign,
  output logic              busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_misalign;

  store_entry_t   w_pack;
  store_entry_t   w_head;
  logic           w_mis;
  logic           w_full;
  logic           w_empty;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;

  store_lane_pack #(.ADDR_W(ADDR_W)) u_pack (
    .i_addr       (st_addr),
    .i_data       (st_data),
    .i_size       (st_size),
    .o_entry      (w_pack),
    .o_misaligned (w_mis)
  );

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_accept = st_valid && !w_full;
  // A dropped store still completes the handshake so the pipeline never hangs.
  assign w_push   = w_accept && !w_mis;
  assign w_pop    = !w_empty && mem_wready;
  assign w_head   = r_mem[r_rptr];

  assign st_ready   = !w_full;
  assign mem_wvalid = !w_empty;
  assign busy       = !w_empty;
  assign mem_waddr  = w_head.waddr[ADDR_W-1:0];
  assign mem_wdata  = w_head.wdata;
  assign mem_wstrb  = w_head.wstrb;
  assign misalign   = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_pack;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_misalign <= w_accept && w_mis;
    end
  end

endmodule

// File: tb/tb_store_pack_buffer.sv
// Directed self-checking bench for store_pack_buffer (DEPTH=2).
module tb_store_pack_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign;
  logic        busy;

  int errors = 0;
  int checks = 0;

  store_pack_buffer #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_size    (st_size),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .misalign   (misalign),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    chk({tag, "_wvalid"}, 64'(mem_wvalid), 64'd1);
    chk({tag, "_waddr"},  64'(mem_waddr),  64'(a));
    chk({tag, "_wdata"},  64'(mem_wdata),  64'(d));
    chk({tag, "_wstrb"},  64'(mem_wstrb),  64'(s));
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_wready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);

    // Reset state
    #12;
    chk("rst_st_ready", 64'(st_ready),   64'd1);
    chk("rst_wvalid",   64'(mem_wvalid), 64'd0);
    chk("rst_waddr",    64'(mem_waddr),  64'd0);
    chk("rst_wdata",    64'(mem_wdata),  64'd0);
    chk("rst_wstrb",    64'(mem_wstrb),  64'd0);
    chk("rst_misalign", 64'(misalign),   64'd0);
    chk("rst_busy",     64'(busy),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte store, lane 3
    @(negedge clk);
    drive(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("byte", 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    chk("byte_busy",     64'(busy),     64'd1);
    chk("byte_st_ready", 64'(st_ready), 64'd1);
    mem_wready = 1'b1;
    @(negedge clk);
    chk("byte_pop_wvalid", 64'(mem_wvalid), 64'd0);
    chk("byte_pop_busy",   64'(busy),       64'd0);

    // Half store, upper half, popped next cycle
    drive(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'b01);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("half", 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    @(negedge clk);
    chk("half_pop_busy",   64'(busy),       64'd0);
    chk("half_pop_wvalid", 64'(mem_wvalid), 64'd0);

    // Backpressure: fill, stall a third store, drain in order
    mem_wready = 1'b0;
    drive(1'b1, 32'h0000_4000, 32'h1111_1111, 2'b10);
    @(negedge clk);
    drive(1'b1, 32'h0000_4004, 32'h2222_2222, 2'b10);
    @(negedge clk);
    chk("bp_full_ready", 64'(st_ready), 64'd0);
    chk_head("bp_a", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    drive(1'b1, 32'h0000_4008, 32'h3333_3333, 2'b10);
    @(negedge clk);
    chk("bp_stall_ready", 64'(st_ready), 64'd0);
    chk_head("bp_a_hold", 32'h0000_4000, 32'h1111_1111, 4'b1111);
    mem_wready = 1'b1;
    @(negedge clk);
    mem_wready = 1'b0;
    chk("bp_pop_ready", 64'(st_ready), 64'd1);
    chk_head("bp_b", 32'h0000_4004, 32'h2222_2222, 4'b1111);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("bp_c_in_ready", 64'(st_ready), 64'd0);
    chk_head("bp_b_hold", 32'h0000_4004, 32'h2222_2222, 4'b1111);
    mem_wready = 1'b1;
    @(negedge clk);
    chk_head("bp_c", 32'h0000_4008, 32'h3333_3333, 4'b1111);
    @(negedge clk);
    chk("bp_drain_wvalid", 64'(mem_wvalid), 64'd0);

    // Misaligned and other lane patterns, back-to-back with mem_wready=1
`ifdef STORE_MISALIGN_TRAP_EN
    drive(1'b1, 32'h0000_3001, 32'hCAFE_F00D, 2'b10);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("mis_pulse",  64'(misalign),   64'd1);
    chk("mis_wvalid", 64'(mem_wvalid), 64'd0);
    @(negedge clk);
    chk("mis_pulse_end", 64'(misalign),   64'd0);
    chk("mis_wvalid2",   64'(mem_wvalid), 64'd0);
    drive(1'b1, 32'h0000_3002, 32'h0000_0000, 2'b11);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("rsvd_pulse",  64'(misalign),   64'd1);
    chk("rsvd_wvalid", 64'(mem_wvalid), 64'd0);
    @(negedge clk);
`else
    drive(1'b1, 32'h0000_3001, 32'hCAFE_F00D, 2'b10);
    @(negedge clk);
    drive(1'b1, 32'h0000_3002, 32'h0102_0304, 2'b11);
    chk_head("mis_word", 32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
    chk("mis_flag", 64'(misalign), 64'd0);
    @(negedge clk);
    drive(1'b1, 32'h0000_6003, 32'h5555_ABCD, 2'b01);
    chk_head("rsvd_word", 32'h0000_3000, 32'h0102_0304, 4'b1111);
    chk("rsvd_flag", 64'(misalign), 64'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("mis_half", 32'h0000_6000, 32'hABCD_ABCD, 4'b1100);
    @(negedge clk);
`endif
    drive(1'b1, 32'h0000_5001, 32'h0000_0077, 2'b00);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk_head("byte_l1", 32'h0000_5000, 32'h7777_7777, 4'b0010);
    @(negedge clk);
    chk("byte_l1_busy", 64'(busy), 64'd0);

    // Reset with two entries buffered
    mem_wready = 1'b0;
    drive(1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    drive(1'b1, 32'h0000_7004, 32'h0BAD_F00D, 2'b10);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    chk("pre_rst_busy",  64'(busy),     64'd1);
    chk("pre_rst_ready", 64'(st_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("mid_rst_busy",   64'(busy),       64'd0);
    chk("mid_rst_ready",  64'(st_ready),   64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wvalid", 64'(mem_wvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
